// File: rtl/alu2_wb_pkg.sv
// alu2_wb_pkg - shared definitions for the alu2 write-back end.
//   Stage state encodings, flag register width and bit positions,
//   and the register-count derivation used by the register file.
package alu2_wb_pkg;

    localparam int WB_FLAG_W = 8;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

    // Bit positions inside the 8-bit flag register as produced by the ALU.
    typedef enum int unsigned {
        FLG_C = 0,
        FLG_Z = 1,
        FLG_N = 2,
        FLG_V = 3,
        FLG_P = 4,
        FLG_H = 5,
        FLG_X = 6,
        FLG_Y = 7
    } flag_bit_e;

    function automatic int nreg(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/alu2_regfile.sv
// alu2_regfile - architectural register file, NREG x WIDTH.
//   clk          rising-edge clock
//   rst_n        asynchronous active-low clear of every register
//   we/waddr/wdata  single synchronous write port
//   ra_addr/ra_data, rb_addr/rb_data  two asynchronous read ports
module alu2_regfile
    import alu2_wb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data
);

    localparam int NREG = nreg(AW);

    logic [NREG-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/alu2_wb.sv
// alu2_wb - write-back end of the alu2 interface.
//   Single-entry stage holding one ALU result until it commits to the
//   register file / flag register; a memory-load write port has priority.
//   clk, reset (async active-low)
//   in_valid/in_ready, in_ra, in_res, in_fo, in_wb_en, in_flag_en : ALU result
//   ld_we, ld_ra, ld_data : memory-load write
//   flush      : drop the pending entry
//   rb_addr/rb_data, rd_addr/rd_data : bypassed operand reads (bi/di)
//   flags      : bypassed flag value (fi)
//   pending    : stage holds an uncommitted entry
module alu2_wb
    import alu2_wb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW-1:0]        in_ra,
    input  logic [WIDTH-1:0]     in_res,
    input  logic [WB_FLAG_W-1:0] in_fo,
    input  logic                 in_wb_en,
    input  logic                 in_flag_en,
    input  logic                 ld_we,
    input  logic [AW-1:0]        ld_ra,
    input  logic [WIDTH-1:0]     ld_data,
    input  logic                 flush,
    input  logic [AW-1:0]        rb_addr,
    output logic [WIDTH-1:0]     rb_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic [WB_FLAG_W-1:0] flags,
    output logic                 pending
);

    typedef struct packed {
        logic [AW-1:0]        ra;
        logic [WIDTH-1:0]     res;
        logic [WB_FLAG_W-1:0] fo;
        logic                 wb_en;
        logic                 flag_en;
    } entry_t;

    wb_state_e            state_q, state_d;
    entry_t               ent_q, ent_d;
    logic [WB_FLAG_W-1:0] flag_q, flag_d;

    logic             full;
    logic             commit;
    logic             accept;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] rf_rb, rf_rd;

    assign full = (state_q == WB_FULL);

    // A load owns the write port this edge, so the entry waits; flush drops it.
    assign commit   = full & ~ld_we & ~flush;
    // Depends only on state, ld_we and flush, never on in_valid.
    assign in_ready = ~full | commit | flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        if (accept) begin
            state_d       = WB_FULL;
            ent_d.ra      = in_ra;
            ent_d.res     = in_res;
            ent_d.fo      = in_fo;
            ent_d.wb_en   = in_wb_en;
            ent_d.flag_en = in_flag_en;
        end else if (full & (commit | flush)) begin
            state_d = WB_EMPTY;
        end
    end

    always_comb begin
        flag_d = flag_q;
        if (commit & ent_q.flag_en) begin
            flag_d = ent_q.fo;
        end
    end

    // Write-port mux: load first, otherwise the committing stage entry.
    always_comb begin
        rf_we    = ld_we | (commit & ent_q.wb_en);
        rf_waddr = ld_we ? ld_ra   : ent_q.ra;
        rf_wdata = ld_we ? ld_data : ent_q.res;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WB_EMPTY;
            ent_q   <= '0;
            flag_q  <= '0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            flag_q  <= flag_d;
        end
    end

    alu2_regfile #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .ra_addr (rb_addr),
        .ra_data (rf_rb),
        .rb_addr (rd_addr),
        .rb_data (rf_rd)
    );

    // The uncommitted entry is the newest value of its register; loads are
    // deliberately not forwarded and show up from the next cycle.
    assign rb_data = (full & ent_q.wb_en & (ent_q.ra == rb_addr)) ? ent_q.res : rf_rb;
    assign rd_data = (full & ent_q.wb_en & (ent_q.ra == rd_addr)) ? ent_q.res : rf_rd;
    assign flags   = (full & ent_q.flag_en) ? ent_q.fo : flag_q;
    assign pending = full;

endmodule

// File: tb/tb_alu2_wb.sv
module tb_alu2_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ra;
    logic [31:0] in_res;
    logic [7:0]  in_fo;
    logic        in_wb_en;
    logic        in_flag_en;
    logic        ld_we;
    logic [3:0]  ld_ra;
    logic [31:0] ld_data;
    logic        flush;
    logic [3:0]  rb_addr;
    logic [31:0] rb_data;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  flags;
    logic        pending;

    alu2_wb #(.WIDTH(32), .AW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ra      (in_ra),
        .in_res     (in_res),
        .in_fo      (in_fo),
        .in_wb_en   (in_wb_en),
        .in_flag_en (in_flag_en),
        .ld_we      (ld_we),
        .ld_ra      (ld_ra),
        .ld_data    (ld_data),
        .flush      (flush),
        .rb_addr    (rb_addr),
        .rb_data    (rb_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .flags      (flags),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] rb;
        logic [31:0] rd;
        logic [7:0]  fl;
        logic        rdy;
        logic        pend;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
        n_check++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, want);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                n_check++;
                n_fail++;
                $display("FAIL %s.missed: sampled cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
            end else begin
                cmp(e.name, "rb_data",  rb_data,         e.rb);
                cmp(e.name, "rd_data",  rd_data,         e.rd);
                cmp(e.name, "flags",    {24'd0, flags},  {24'd0, e.fl});
                cmp(e.name, "in_ready", {31'd0, in_ready}, {31'd0, e.rdy});
                cmp(e.name, "pending",  {31'd0, pending},  {31'd0, e.pend});
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] ra, input logic [31:0] res,
                         input logic [7:0] fo, input logic wb, input logic fe,
                         input logic lw, input logic [3:0] lra, input logic [31:0] ld,
                         input logic fl, input logic [3:0] a_b, input logic [3:0] a_d);
        in_valid   = v;
        in_ra      = ra;
        in_res     = res;
        in_fo      = fo;
        in_wb_en   = wb;
        in_flag_en = fe;
        ld_we      = lw;
        ld_ra      = lra;
        ld_data    = ld;
        flush      = fl;
        rb_addr    = a_b;
        rd_addr    = a_d;
    endtask

    task automatic idle(input logic [3:0] a_b, input logic [3:0] a_d);
        drive(0, 4'd0, 32'd0, 8'd0, 0, 0, 0, 4'd0, 32'd0, 0, a_b, a_d);
    endtask

    task automatic expect_now(input string nm, input logic [31:0] rb, input logic [31:0] rd,
                              input logic [7:0] fl, input logic rdy, input logic pend);
        exp_t e;
        e.name = nm; e.cyc = cyc; e.rb = rb; e.rd = rd; e.fl = fl; e.rdy = rdy; e.pend = pend;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] old_rb [5];
        old_rb[0] = 32'h0; old_rb[1] = 32'h0; old_rb[2] = 32'h11; old_rb[3] = 32'h0; old_rb[4] = 32'h0;

        // 1. reset
        reset = 1'b0;
        idle(4'd3, 4'd15);
        tick();
        expect_now("in_reset", 0, 0, 8'h00, 1, 0);
        tick();
        reset = 1'b1;
        expect_now("post_reset", 0, 0, 8'h00, 1, 0);
        tick();

        // 2. accept, bypass, commit
        drive(1, 4'd5, 32'hDEADBEEF, 8'h0C, 1, 1, 0, 4'd0, 32'd0, 0, 4'd5, 4'd5);
        expect_now("acc5_empty", 0, 0, 8'h00, 1, 0);
        tick();
        idle(4'd5, 4'd5);
        expect_now("acc5_bypass", 32'hDEADBEEF, 32'hDEADBEEF, 8'h0C, 1, 1);
        tick();
        expect_now("acc5_commit", 32'hDEADBEEF, 32'hDEADBEEF, 8'h0C, 1, 0);
        tick();

        // 3. load blocks commit; stage entry wins on the same register
        drive(1, 4'd2, 32'h11, 8'h00, 1, 0, 0, 4'd0, 32'd0, 0, 4'd2, 4'd5);
        expect_now("acc2", 0, 32'hDEADBEEF, 8'h0C, 1, 0);
        tick();
        drive(1, 4'd8, 32'h888, 8'h00, 1, 0, 1, 4'd2, 32'h22, 0, 4'd2, 4'd8);
        expect_now("ld_block", 32'h11, 0, 8'h0C, 0, 1);
        tick();
        idle(4'd2, 4'd8);
        expect_now("ld_after", 32'h11, 0, 8'h0C, 1, 1);
        tick();
        expect_now("ld_stage_wins", 32'h11, 0, 8'h0C, 1, 0);
        tick();

        // load data is not bypassed, visible next cycle
        drive(0, 4'd0, 32'd0, 8'd0, 0, 0, 1, 4'd10, 32'hA5A5, 0, 4'd10, 4'd2);
        expect_now("ld_nobypass", 0, 32'h11, 8'h0C, 1, 0);
        tick();
        idle(4'd10, 4'd2);
        expect_now("ld_visible", 32'hA5A5, 32'h11, 8'h0C, 1, 0);
        tick();

        // 4. back-to-back accepts
        for (int k = 1; k <= 4; k++) begin
            logic [3:0] a;
            logic [3:0] ap;
            a  = k[3:0];
            ap = a - 4'd1;
            drive(1, a, 32'h100 * k, 8'h00, 1, 0, 0, 4'd0, 32'd0, 0, a, ap);
            expect_now($sformatf("b2b_%0d", k), old_rb[k], 32'h100 * (k - 1), 8'h0C, 1, (k > 1));
            tick();
        end
        idle(4'd4, 4'd1);
        expect_now("b2b_tail", 32'h400, 32'h100, 8'h0C, 1, 1);
        tick();
        idle(4'd2, 4'd3);
        expect_now("b2b_final", 32'h200, 32'h300, 8'h0C, 1, 0);
        tick();

        // 5. flush drops entry, no reg or flag write
        drive(1, 4'd7, 32'h55, 8'hFF, 1, 1, 0, 4'd0, 32'd0, 0, 4'd7, 4'd7);
        expect_now("acc7", 0, 0, 8'h0C, 1, 0);
        tick();
        drive(0, 4'd0, 32'd0, 8'd0, 0, 0, 0, 4'd0, 32'd0, 1, 4'd7, 4'd7);
        expect_now("flush7", 32'h55, 32'h55, 8'hFF, 1, 1);
        tick();
        idle(4'd7, 4'd7);
        expect_now("flush7_after", 0, 0, 8'h0C, 1, 0);
        tick();

        // flush with simultaneous accept and load
        drive(1, 4'd6, 32'h66, 8'h00, 1, 0, 0, 4'd0, 32'd0, 0, 4'd6, 4'd11);
        expect_now("acc6", 0, 0, 8'h0C, 1, 0);
        tick();
        drive(1, 4'd6, 32'h77, 8'h00, 1, 0, 1, 4'd11, 32'hBB, 1, 4'd6, 4'd11);
        expect_now("flush_acc", 32'h66, 0, 8'h0C, 1, 1);
        tick();
        idle(4'd6, 4'd11);
        expect_now("flush_repl", 32'h77, 32'hBB, 8'h0C, 1, 1);
        tick();
        expect_now("flush_repl_commit", 32'h77, 32'hBB, 8'h0C, 1, 0);
        tick();

        // 6. reset while FULL
        drive(1, 4'd9, 32'h99, 8'h00, 1, 0, 0, 4'd0, 32'd0, 0, 4'd9, 4'd4);
        expect_now("acc9", 0, 32'h400, 8'h0C, 1, 0);
        tick();
        drive(0, 4'd0, 32'd0, 8'd0, 0, 0, 1, 4'd12, 32'h12, 0, 4'd9, 4'd4);
        expect_now("hold9", 32'h99, 32'h400, 8'h0C, 0, 1);
        tick();
        idle(4'd9, 4'd4);
        reset = 1'b0;
        expect_now("mid_reset", 0, 0, 8'h00, 1, 0);
        tick();
        reset = 1'b1;
        idle(4'd9, 4'd12);
        expect_now("after_reset", 0, 0, 8'h00, 1, 0);
        tick();

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_check++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
